// File: rtl/config_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : config_loader_pkg
//  Description : Shared constants and state encoding for the config loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package config_loader_pkg;

    localparam int c_config_width = 34688;
    localparam int c_word_width   = 32;
    localparam int c_clear_cycles = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/config_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : config_loader_if
//  Description : Bitstream word stream (valid/ready) into the config loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface config_loader_if #(
    parameter int WORD_WIDTH = 32
) ();

    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );

endinterface
`default_nettype wire

// File: rtl/config_loader_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : config_word_serializer
//  Description : Holds one bitstream word and presents it MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_word_serializer #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] load_data,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  last_bit
);

    localparam int c_cnt_w = $clog2(WORD_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WORD_WIDTH - 1);

    logic [WORD_WIDTH-1:0] r_word;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic                  r_empty;

    // A load on the last bit cycle replaces the word with no gap between words.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_word    <= '0;
            r_bit_cnt <= '0;
            r_empty   <= 1'b1;
        end else if (load) begin
            r_word    <= load_data;
            r_bit_cnt <= c_last_idx;
            r_empty   <= 1'b0;
        end else if (!r_empty) begin
            if (r_bit_cnt == '0) begin
                r_empty <= 1'b1;
            end else begin
                r_word    <= {r_word[WORD_WIDTH-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - c_cnt_w'(1);
            end
        end
    end

    assign bit_out   = r_word[WORD_WIDTH-1];
    assign bit_valid = !r_empty;
    assign last_bit  = !r_empty && (r_bit_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : config_loader
//  Description : Streams a full bitstream serially into the core config chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = c_config_width,
    parameter int WORD_WIDTH   = c_word_width,
    parameter int CLEAR_CYCLES = c_clear_cycles
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    config_loader_if.slave  word_if,
    output logic            config_in,
    output logic            config_enable,
    output logic            config_nreset,
    output logic            busy,
    output logic            done
);

    localparam int c_num_words_i = CONFIG_WIDTH / WORD_WIDTH;
    localparam int c_wcnt_w      = $clog2(c_num_words_i) + 1;
    localparam int c_clr_w       = $clog2(CLEAR_CYCLES) + 1;
    localparam logic [c_wcnt_w-1:0] c_num_words = c_wcnt_w'(c_num_words_i);
    localparam logic [c_clr_w-1:0]  c_clr_last  = c_clr_w'(CLEAR_CYCLES - 1);

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic [c_wcnt_w-1:0]   r_word_cnt;
    logic [c_clr_w-1:0]    r_clr_cnt;
    logic                  w_ready;
    logic                  w_enable;
    logic                  w_accept;
    logic                  w_start_load;
    logic                  w_ser_flush;
    logic                  w_ser_bit;
    logic                  w_ser_valid;
    logic                  w_ser_last;

    assign w_start_load = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !abort;
    assign w_accept     = w_ready && word_if.word_valid;
    assign w_ser_flush  = (r_state != ST_SHIFT) || abort;
    assign word_if.word_ready = w_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort gates enable and ready in its own cycle so nothing more reaches the chain.
    always_comb begin
        w_state_next  = r_state;
        w_ready       = 1'b0;
        w_enable      = 1'b0;
        config_nreset = 1'b1;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                done = (r_state == ST_DONE);
                if (start && !abort) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy          = 1'b1;
                config_nreset = 1'b0;
                if (abort)                        w_state_next = ST_IDLE;
                else if (r_clr_cnt == c_clr_last) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_ready  = (r_word_cnt != c_num_words) && (!w_ser_valid || w_ser_last);
                    w_enable = w_ser_valid;
                    if (w_ser_last && (r_word_cnt == c_num_words)) w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        config_enable = w_enable;
        config_in     = w_enable & w_ser_bit;
    end

    always_ff @(posedge clock) begin
        if (reset || w_start_load) begin
            r_word_cnt <= '0;
            r_clr_cnt  <= '0;
        end else begin
            if (r_state == ST_CLEAR) r_clr_cnt  <= r_clr_cnt + c_clr_w'(1);
            if (w_accept)            r_word_cnt <= r_word_cnt + c_wcnt_w'(1);
        end
    end

    config_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clk       (clock),
        .rst       (reset),
        .flush     (w_ser_flush),
        .load      (w_accept),
        .load_data (word_if.word_data),
        .bit_out   (w_ser_bit),
        .bit_valid (w_ser_valid),
        .last_bit  (w_ser_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_config_loader
//  Description : Directed self-checking bench with a model config shift chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_config_loader;

    localparam int CW  = 34688;
    localparam int WW  = 32;
    localparam int NW  = CW / WW;
    localparam int CLR = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic config_in, config_enable, config_nreset, busy, done;

    config_loader_if #(.WORD_WIDTH(WW)) wif ();

    config_loader #(
        .CONFIG_WIDTH (CW),
        .WORD_WIDTH   (WW),
        .CLEAR_CYCLES (CLR)
    ) dut (
        .clock         (clk),
        .reset         (rst),
        .start         (start),
        .abort         (abort),
        .word_if       (wif),
        .config_in     (config_in),
        .config_enable (config_enable),
        .config_nreset (config_nreset),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WW-1:0] words [NW];
    logic [CW-1:0] model_sr;
    logic [31:0]   first_bits;
    int cyc = 0, nreset_cnt = 0, en_cnt = 0, en_first = -1, en_last = -1, done_cyc = -1, bad_in = 0;

    // Reference config chain plus event bookkeeping, sampled at the active edge.
    always @(posedge clk) begin
        if (!config_nreset) begin
            model_sr <= '0;
            nreset_cnt++;
        end else if (config_enable) begin
            model_sr <= {model_sr[CW-2:0], config_in};
        end
        if (config_enable) begin
            if (en_first < 0) en_first = cyc;
            en_last = cyc;
            if (en_cnt < 32) first_bits[31-en_cnt] = config_in;
            en_cnt++;
        end
        if (!config_enable && config_in) bad_in++;
        if (done && done_cyc < 0) done_cyc = cyc;
        cyc++;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        nreset_cnt = 0; en_cnt = 0; en_first = -1; en_last = -1;
        done_cyc = -1; bad_in = 0; first_bits = '0;
    endtask

    task automatic fill_words(input logic [31:0] seed, input logic [31:0] w0);
        for (int i = 0; i < NW; i++) words[i] = (i * 32'h9E37_79B9) ^ seed;
        words[0] = w0;
    endtask

    function automatic int image_mismatches();
        int m = 0;
        for (int i = 0; i < NW; i++)
            if (model_sr[CW-1-WW*i -: WW] !== words[i]) m++;
        return m;
    endfunction

    task automatic drive_load(input int starve_word, input int midstart_word, input int abort_word);
        int idx = 0, budget = CW + 1000, starve_left = 10;
        bit starving = 0, ms_done = 0, v, acc;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (budget > 0 && done !== 1'b1) begin
            if (abort_word >= 0 && idx == abort_word + 1) begin
                wif.word_valid = 1'b0;
                start = 1'b1;
                abort = 1'b1;
                tick;
                start = 1'b0;
                abort = 1'b0;
                break;
            end
            v = (idx < NW);
            if (starve_word >= 0 && idx == starve_word + 1 && starve_left > 0 &&
                (starving || wif.word_ready === 1'b1)) begin
                starving = 1; starve_left--; v = 0;
            end else begin
                starving = 0;
            end
            start = (midstart_word >= 0 && idx == midstart_word + 1 && !ms_done);
            if (start) ms_done = 1;
            wif.word_valid = v;
            wif.word_data  = v ? words[idx] : '0;
            @(negedge clk);
            acc = v && (wif.word_ready === 1'b1);
            tick;
            if (acc) idx++;
            budget--;
        end
        wif.word_valid = 1'b0;
        start = 1'b0;
        checks++;
        if (budget <= 0) begin
            failures++;
            $display("FAIL load_timeout: words_accepted=%0d required load to finish", idx);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        checks++;
        if ({wif.word_ready, config_in, config_enable, config_nreset, busy, done} !== 6'b000100) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000100",
                     {wif.word_ready, config_in, config_enable, config_nreset, busy, done});
        end
        rst = 1'b0;
        tick;
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || config_nreset !== 1'b1) begin
            failures++;
            $display("FAIL start_abort_idle: busy=%b nreset=%b expected busy=0 nreset=1", busy, config_nreset);
        end
    endtask

    task automatic test_full_load;
        fill_words(32'h1234_5678, 32'h8000_0001);
        clear_mon;
        drive_load(5, -1, -1);
        tick;
        checks++;
        if (en_cnt !== CW) begin failures++; $display("FAIL full_en_count: got %0d expected %0d", en_cnt, CW); end
        checks++;
        if (nreset_cnt !== CLR) begin failures++; $display("FAIL full_clear_cycles: got %0d expected %0d", nreset_cnt, CLR); end
        checks++;
        if (en_last - en_first + 1 !== CW + 10) begin
            failures++; $display("FAIL starve_span: got %0d expected %0d", en_last - en_first + 1, CW + 10);
        end
        checks++;
        if (done_cyc !== en_last + 1) begin failures++; $display("FAIL done_timing: got %0d expected %0d", done_cyc, en_last + 1); end
        checks++;
        if (first_bits !== 32'h8000_0001) begin failures++; $display("FAIL first_word_bits: got %h expected 80000001", first_bits); end
        checks++;
        if (model_sr[CW-1] !== 1'b1) begin failures++; $display("FAIL msb_position: got %b expected 1", model_sr[CW-1]); end
        checks++;
        if (image_mismatches() !== 0) begin failures++; $display("FAIL full_image: got %0d bad words expected 0", image_mismatches()); end
        checks++;
        if (bad_in !== 0) begin failures++; $display("FAIL config_in_idle: got %0d cycles expected 0", bad_in); end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL full_done_flags: done=%b busy=%b expected 1 0", done, busy); end
    endtask

    task automatic test_abort_midstart;
        int en_at;
        fill_words(32'hCAFE_F00D, 32'h0F0F_0F0F);
        clear_mon;
        drive_load(-1, 50, 100);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || config_enable !== 1'b0) begin
            failures++; $display("FAIL abort_state: busy=%b done=%b en=%b expected 0 0 0", busy, done, config_enable);
        end
        en_at = en_cnt;
        repeat (50) tick;
        checks++;
        if (en_cnt !== en_at) begin failures++; $display("FAIL abort_no_enables: got %0d expected %0d", en_cnt, en_at); end
        checks++;
        if (en_cnt !== 100 * WW) begin failures++; $display("FAIL abort_en_count: got %0d expected %0d", en_cnt, 100 * WW); end
        checks++;
        if (nreset_cnt !== CLR) begin failures++; $display("FAIL midstart_ignored: clear cycles got %0d expected %0d", nreset_cnt, CLR); end
        checks++;
        if (done !== 1'b0 || wif.word_ready !== 1'b0) begin
            failures++; $display("FAIL abort_idle_flags: done=%b ready=%b expected 0 0", done, wif.word_ready);
        end
    endtask

    task automatic test_reload;
        fill_words(32'h5A5A_3C3C, 32'hDEAD_BEEF);
        clear_mon;
        drive_load(-1, -1, -1);
        tick;
        checks++;
        if (en_cnt !== CW) begin failures++; $display("FAIL reload_en_count: got %0d expected %0d", en_cnt, CW); end
        checks++;
        if (en_last - en_first + 1 !== CW) begin
            failures++; $display("FAIL reload_contiguous: got %0d expected %0d", en_last - en_first + 1, CW);
        end
        checks++;
        if (image_mismatches() !== 0) begin failures++; $display("FAIL reload_image: got %0d bad words expected 0", image_mismatches()); end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL reload_done: got %b expected 1", done); end
    endtask

    task automatic test_reset_mid_shift;
        int en_at;
        clear_mon;
        start = 1'b1;
        tick;
        start = 1'b0;
        wif.word_valid = 1'b1;
        wif.word_data  = 32'hA5A5_A5A5;
        repeat (60) tick;
        checks++;
        if (busy !== 1'b1 || en_cnt == 0) begin failures++; $display("FAIL pre_reset_shift: busy=%b en=%0d expected busy=1", busy, en_cnt); end
        rst = 1'b1;
        tick;
        checks++;
        if ({wif.word_ready, config_in, config_enable, config_nreset, busy, done} !== 6'b000100) begin
            failures++;
            $display("FAIL reset_mid_shift: got %b expected 000100",
                     {wif.word_ready, config_in, config_enable, config_nreset, busy, done});
        end
        en_at = en_cnt;
        rst = 1'b0;
        wif.word_valid = 1'b0;
        repeat (5) tick;
        checks++;
        if (en_cnt !== en_at || busy !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle: en=%0d busy=%b expected en=%0d busy=0", en_cnt, busy, en_at);
        end
    endtask

    initial begin
        wif.word_valid = 1'b0;
        wif.word_data  = '0;
        test_reset;
        test_full_load;
        test_abort_midstart;
        test_reload;
        test_reset_mid_shift;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
